// File: rtl/projectile_pkg.sv
// Shared state encoding, fixed-point types and screen-limit helpers for the projectile pool.
package projectile_pkg;

  typedef enum logic {COLLECT = 1'b0, UPDATE = 1'b1} state_t;

  localparam int FRAC_BITS_DEF = 6;
  localparam int FX_W_DEF      = 12 + FRAC_BITS_DEF;

  typedef logic signed [FX_W_DEF-1:0] fx_t;

  typedef struct packed {
    logic active;
    fx_t  x;
    fx_t  y;
    fx_t  vx;
    fx_t  vy;
  } slot_t;

  function automatic int lim_low(input int margin, input int frac);
    return margin << frac;
  endfunction

  // Largest top-left coordinate that keeps the whole object inside the margin.
  function automatic int lim_high(input int extent, input int margin, input int obj, input int frac);
    return (extent - 1 - margin - obj) << frac;
  endfunction

endpackage

// File: rtl/projectile_step.sv
// Combinational single-slot motion step: gravity with speed clamp, position add, edge handling.
module projectile_step
  import projectile_pkg::*;
#(
  parameter int FRAC_BITS   = 6,
  parameter int FX_W        = 12 + FRAC_BITS,
  parameter int OBJ_W       = 16,
  parameter int OBJ_H       = 16,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int MARGIN      = 2,
  parameter int Y_ACCEL     = 10,
  parameter int MAX_Y_SPEED = 100,
  parameter int EDGE_MODE   = 0
) (
  input  logic signed [FX_W-1:0] x,
  input  logic signed [FX_W-1:0] y,
  input  logic signed [FX_W-1:0] vx,
  input  logic signed [FX_W-1:0] vy,
  output logic signed [FX_W-1:0] nx,
  output logic signed [FX_W-1:0] ny,
  output logic signed [FX_W-1:0] nvx,
  output logic signed [FX_W-1:0] nvy,
  output logic                   alive
);

  localparam logic signed [FX_W-1:0] LIM_L = FX_W'(lim_low(MARGIN, FRAC_BITS));
  localparam logic signed [FX_W-1:0] LIM_R = FX_W'(lim_high(SCREEN_W, MARGIN, OBJ_W, FRAC_BITS));
  localparam logic signed [FX_W-1:0] LIM_T = FX_W'(lim_low(MARGIN, FRAC_BITS));
  localparam logic signed [FX_W-1:0] LIM_B = FX_W'(lim_high(SCREEN_H, MARGIN, OBJ_H, FRAC_BITS));
  localparam logic signed [FX_W-1:0] ACC   = FX_W'(Y_ACCEL);
  localparam logic signed [FX_W-1:0] VMAX  = FX_W'(MAX_Y_SPEED);

  logic signed [FX_W-1:0] vy_acc, vy_clamp, xs, ys;

  always_comb begin
    vy_acc = vy + ACC;
    if (vy_acc > VMAX)       vy_clamp = VMAX;
    else if (vy_acc < -VMAX) vy_clamp = -VMAX;
    else                     vy_clamp = vy_acc;

    xs    = x + vx;
    ys    = y + vy_clamp;
    nx    = xs;
    ny    = ys;
    nvx   = vx;
    nvy   = vy_clamp;
    alive = 1'b1;

    if (EDGE_MODE == 0) begin
      alive = !((xs < LIM_L) || (xs > LIM_R) || (ys < LIM_T) || (ys > LIM_B));
    end else begin
      // Reflect only when moving into the wall, so a clamped object cannot get stuck flipping.
      if (xs < LIM_L) begin
        nx = LIM_L;
        if (vx < 0) nvx = -vx;
      end else if (xs > LIM_R) begin
        nx = LIM_R;
        if (vx > 0) nvx = -vx;
      end
      if (ys < LIM_T) begin
        ny = LIM_T;
        if (vy_clamp < 0) nvy = -vy_clamp;
      end else if (ys > LIM_B) begin
        ny = LIM_B;
        if (vy_clamp > 0) nvy = -vy_clamp;
      end
    end
  end

endmodule

// File: rtl/projectile_pool.sv
// Multi-slot projectile pool: spawn allocation, sticky hit capture, and a per-frame
// update that time-multiplexes one projectile_step over all slots.
module projectile_pool
  import projectile_pkg::*;
#(
  parameter int NUM_SLOTS   = 4,
  parameter int FRAC_BITS   = 6,
  parameter int OBJ_W       = 16,
  parameter int OBJ_H       = 16,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int MARGIN      = 2,
  parameter int Y_ACCEL     = 10,
  parameter int MAX_Y_SPEED = 100,
  parameter int EDGE_MODE   = 0,
  parameter int IDX_W       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     startOfFrame,
  input  logic                     spawn_req,
  input  logic [10:0]              spawn_x,
  input  logic [10:0]              spawn_y,
  input  logic signed [10:0]       spawn_vx,
  input  logic signed [10:0]       spawn_vy,
  output logic                     spawn_ack,
  output logic [IDX_W-1:0]         spawn_slot,
  output logic                     full,
  input  logic [NUM_SLOTS-1:0]     hit,
  output logic [NUM_SLOTS-1:0]     active,
  output logic [NUM_SLOTS*11-1:0]  topLeftX,
  output logic [NUM_SLOTS*11-1:0]  topLeftY,
  output logic                     overrun
);

  localparam int FX_W = 12 + FRAC_BITS;

  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic [NUM_SLOTS-1:0]   hit_reg;
  logic signed [FX_W-1:0] x [NUM_SLOTS];
  logic signed [FX_W-1:0] y [NUM_SLOTS];
  logic signed [FX_W-1:0] vx [NUM_SLOTS];
  logic signed [FX_W-1:0] vy [NUM_SLOTS];
  logic signed [FX_W-1:0] nx, ny, nvx, nvy;
  logic signed [FX_W-1:0] spawn_px, spawn_py;
  logic                   alive;

  assign full      = &active;
  assign spawn_ack = spawn_req & ~full & (state == COLLECT);
  assign spawn_px  = {1'b0, spawn_x, {FRAC_BITS{1'b0}}};
  assign spawn_py  = {1'b0, spawn_y, {FRAC_BITS{1'b0}}};

  always_comb begin
    spawn_slot = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!active[i]) spawn_slot = IDX_W'(i);
    end
  end

  projectile_step #(
    .FRAC_BITS(FRAC_BITS), .FX_W(FX_W), .OBJ_W(OBJ_W), .OBJ_H(OBJ_H),
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .MARGIN(MARGIN),
    .Y_ACCEL(Y_ACCEL), .MAX_Y_SPEED(MAX_Y_SPEED), .EDGE_MODE(EDGE_MODE)
  ) u_step (
    .x(x[idx]), .y(y[idx]), .vx(vx[idx]), .vy(vy[idx]),
    .nx(nx), .ny(ny), .nvx(nvx), .nvy(nvy), .alive(alive)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= COLLECT;
      idx      <= '0;
      active   <= '0;
      hit_reg  <= '0;
      overrun  <= 1'b0;
      topLeftX <= '0;
      topLeftY <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x[i]  <= '0;
        y[i]  <= '0;
        vx[i] <= '0;
        vy[i] <= '0;
      end
    end else begin
      overrun <= (state == UPDATE) && startOfFrame;
      // Later per-slot clears below take priority over this capture.
      hit_reg <= hit_reg | (hit & active);
      case (state)
        COLLECT: begin
          if (spawn_ack) begin
            x[spawn_slot]                 <= spawn_px;
            y[spawn_slot]                 <= spawn_py;
            vx[spawn_slot]                <= FX_W'(spawn_vx);
            vy[spawn_slot]                <= FX_W'(spawn_vy);
            active[spawn_slot]            <= 1'b1;
            hit_reg[spawn_slot]           <= 1'b0;
            topLeftX[spawn_slot*11 +: 11] <= spawn_x;
            topLeftY[spawn_slot*11 +: 11] <= spawn_y;
          end
          if (startOfFrame) begin
            state <= UPDATE;
            idx   <= '0;
          end
        end
        UPDATE: begin
          if (active[idx]) begin
            if (hit_reg[idx]) begin
              active[idx]  <= 1'b0;
              hit_reg[idx] <= 1'b0;
            end else begin
              x[idx]               <= nx;
              y[idx]               <= ny;
              vx[idx]              <= nvx;
              vy[idx]              <= nvy;
              active[idx]          <= alive;
              topLeftX[idx*11 +: 11] <= nx[FRAC_BITS+10:FRAC_BITS];
              topLeftY[idx*11 +: 11] <= ny[FRAC_BITS+10:FRAC_BITS];
            end
          end
          if (idx == IDX_W'(NUM_SLOTS - 1)) state <= COLLECT;
          else                              idx   <= idx + IDX_W'(1);
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_projectile_pool.sv
// Directed bench for projectile_pool: one instance per edge mode, shared stimulus.
module tb_projectile_pool;
  import projectile_pkg::*;

  localparam int NS = 4;

  logic clk = 1'b0;
  logic reset, sof, spawn_req;
  logic [10:0] spawn_x, spawn_y;
  logic signed [10:0] spawn_vx, spawn_vy;
  logic [NS-1:0] hit;

  logic ack0, ack1, full0, full1, ovr0, ovr1;
  logic [1:0] slot0, slot1;
  logic [NS-1:0] active0, active1;
  logic [NS*11-1:0] tlx0, tly0, tlx1, tly1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  projectile_pool #(.NUM_SLOTS(NS), .EDGE_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .startOfFrame(sof), .spawn_req(spawn_req),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_vx(spawn_vx), .spawn_vy(spawn_vy),
    .spawn_ack(ack0), .spawn_slot(slot0), .full(full0), .hit(hit), .active(active0),
    .topLeftX(tlx0), .topLeftY(tly0), .overrun(ovr0)
  );

  projectile_pool #(.NUM_SLOTS(NS), .EDGE_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .startOfFrame(sof), .spawn_req(spawn_req),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_vx(spawn_vx), .spawn_vy(spawn_vy),
    .spawn_ack(ack1), .spawn_slot(slot1), .full(full1), .hit(hit), .active(active1),
    .topLeftX(tlx1), .topLeftY(tly1), .overrun(ovr1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic int px(input logic [NS*11-1:0] v, input int i);
    logic signed [10:0] p;
    p = v[i*11 +: 11];
    return int'(p);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    sof = 1'b1;
    tick();
    sof = 1'b0;
    repeat (NS) tick();
  endtask

  initial begin
    reset = 1'b1; sof = 1'b0; spawn_req = 1'b0; hit = '0;
    spawn_x = '0; spawn_y = '0; spawn_vx = '0; spawn_vy = '0;
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_active", active0, 0);
    chk("rst_full", full0, 0);
    chk("rst_ack", ack0, 0);
    chk("rst_overrun", ovr0, 0);
    chk("rst_tlx", tlx0, 0);
    chk("rst_tly", tly0, 0);

    // Slot 0 busy, then the (100,50) projectile must land in slot 1.
    spawn_req = 1'b1; spawn_x = 200; spawn_y = 200; spawn_vx = 0; spawn_vy = 0;
    #1;
    chk("ack_s0", ack0, 1);
    chk("slot_s0", slot0, 0);
    tick();
    spawn_x = 100; spawn_y = 50; spawn_vx = 64;
    #1;
    chk("ack_s1", ack0, 1);
    chk("slot_s1", slot0, 1);
    tick();
    spawn_req = 1'b0;
    chk("active_01", active0, 4'b0011);
    chk("tlx1_spawn", px(tlx0, 1), 100);
    chk("tly1_spawn", px(tly0, 1), 50);

    // Gravity: vy = 10,20,..,100 then held at 100; y = 3200 + running sum of vy.
    for (int f = 1; f <= 12; f++) begin
      frame();
      chk("vy1", dut0.vy[1], (f * 10 > 100) ? 100 : f * 10);
      if (f == 1) chk("tly1_f1", px(tly0, 1), 50);
      if (f == 3) chk("tly1_f3", px(tly0, 1), 50);
      if (f == 4) chk("tly1_f4", px(tly0, 1), 51);
    end
    chk("tly1_f12", px(tly0, 1), 61);
    chk("tlx1_f12", px(tlx0, 1), 112);

    // Back-to-back startOfFrame plus a spawn request held through UPDATE.
    sof = 1'b1;
    tick();
    chk("ovr_first", ovr0, 0);
    tick();
    sof = 1'b0;
    chk("ovr_second", ovr0, 1);
    chk("tly1_pre_update", px(tly0, 1), 61);
    spawn_req = 1'b1; spawn_x = 300; spawn_y = 300; spawn_vx = 0; spawn_vy = 0;
    #1;
    chk("ack_upd_a", ack0, 0);
    tick();
    chk("ovr_clear", ovr0, 0);
    chk("tly1_post_update", px(tly0, 1), 63);
    chk("ack_upd_b", ack0, 0);
    tick();
    chk("ack_upd_c", ack0, 0);
    tick();
    chk("ack_collect", ack0, 1);
    chk("slot_collect", slot0, 2);
    tick();
    spawn_req = 1'b0;
    chk("active_012", active0, 4'b0111);
    chk("tly1_single_update", px(tly0, 1), 63);

    // Fill the pool, then kill slot 2 with a hit.
    spawn_req = 1'b1; spawn_x = 400; spawn_y = 100;
    #1;
    chk("ack_s3", ack0, 1);
    chk("slot_s3", slot0, 3);
    tick();
    chk("active_full", active0, 4'b1111);
    chk("full_set", full0, 1);
    chk("ack_when_full", ack0, 0);
    spawn_req = 1'b0;
    hit = 4'b0100;
    tick();
    hit = '0;
    frame();
    chk("active_hit2", active0, 4'b1011);
    chk("full_clear", full0, 0);
    spawn_req = 1'b1; spawn_x = 50; spawn_y = 60;
    #1;
    chk("ack_reuse", ack0, 1);
    chk("slot_reuse", slot0, 2);
    tick();
    spawn_req = 1'b0;
    chk("tlx2_reuse", px(tlx0, 2), 50);
    chk("tly2_reuse", px(tly0, 2), 60);

    // Reset while the update is on slot 1.
    sof = 1'b1;
    tick();
    sof = 1'b0;
    tick();
    chk("idx_mid", dut0.idx, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_active", active0, 0);
    chk("mid_rst_tlx", tlx0, 0);
    chk("mid_rst_tly", tly0, 0);
    chk("mid_rst_x0", dut0.x[0], 0);
    chk("mid_rst_state", dut0.state, COLLECT);

    // Right limit R = (640-1-2-16) << 6 = 39744 (621 px); 620 px + 4 px crosses it.
    spawn_req = 1'b1; spawn_x = 620; spawn_y = 100; spawn_vx = 256; spawn_vy = 0;
    #1;
    chk("edge_ack0", ack0, 1);
    chk("edge_ack1", ack1, 1);
    tick();
    spawn_req = 1'b0;
    chk("edge_tlx_spawn", px(tlx1, 0), 620);
    frame();
    chk("edge0_despawn", active0, 0);
    chk("edge1_alive", active1, 4'b0001);
    chk("edge1_clamp", px(tlx1, 0), 621);
    chk("edge1_vx", dut1.vx[0], -256);
    frame();
    chk("edge1_bounce", px(tlx1, 0), 617);
    chk("edge0_stays_dead", active0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
